// File: rtl/coef_rom_arbiter.sv
// coef_rom_arbiter
// Shares the single sine/cos2x coefficient ROM between the two DDS channel
// evaluators. Requests are arbitrated round-robin; the winner's address and
// chip-enable go to the ROM. A tag pipeline as deep as the ROM read latency
// records which channel owns each in-flight read. The returned word is then
// registered into that channel's result with a one-cycle valid pulse.
//
// Ports
//   Fg_CLK    system clock, rising edge
//   RESETn    asynchronous active-low reset
//   en        arbiter enable; low blocks new grants only
//   req0/1    channel read request, held with addr stable until its grant
//   addr0/1   channel read address
//   gnt0/1    channel grant, one-cycle combinational pulse
//   rvalid0/1 channel result valid, one-cycle registered pulse
//   rdata0/1  channel result word, held until that channel's next result
//   rom_ad    ROM address
//   rom_ce    ROM clock enable
//   rom_dout  ROM read data ([47:24] sine, [23:0] cos2x)
//   busy      at least one read in flight
module coef_rom_arbiter #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 48,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              en,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rom_ad,
  output logic              rom_ce,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              busy
);

  // Round-robin pointer: which channel was granted most recently.
  typedef enum logic {
    LAST_CH0 = 1'b0,
    LAST_CH1 = 1'b1
  } last_e;

  last_e             last_q;
  last_e             last_d;
  logic              grant;
  logic [ADDR_W-1:0] last_ad;

  // Tag pipeline: one {valid, channel} entry per ROM latency stage.
  logic [ROM_LAT-1:0] tag_v;
  logic [ROM_LAT-1:0] tag_ch;
  logic               ret_v;
  logic               ret_ch;

  // Arbitration. A lone requester always wins. On a tie the channel that was
  // not granted last wins, so continuous contention alternates 0,1,0,1.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && (!req1 || last_q == LAST_CH1)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign grant = gnt0 | gnt1;

  always_comb begin
    last_d = last_q;
    if (gnt0) begin
      last_d = LAST_CH0;
    end else if (gnt1) begin
      last_d = LAST_CH1;
    end
  end

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      last_q <= LAST_CH1;
    end else begin
      last_q <= last_d;
    end
  end

  // Address path. The address is held between grants, so the ROM pins stay
  // quiet while it is idle.
  always_comb begin
    rom_ad = last_ad;
    if (gnt0) begin
      rom_ad = addr0;
    end else if (gnt1) begin
      rom_ad = addr1;
    end
  end

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      last_ad <= '0;
    end else begin
      last_ad <= rom_ad;
    end
  end

  assign busy   = |tag_v;
  assign rom_ce = grant | busy;

  // Stage 0 captures the grant at the edge that also samples rom_ad. The
  // final stage is therefore valid in the same cycle as rom_dout for that read.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      tag_v  <= '0;
      tag_ch <= '0;
    end else begin
      tag_v[0]  <= grant;
      tag_ch[0] <= gnt1;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_ch[i] <= tag_ch[i-1];
      end
    end
  end

  assign ret_v  = tag_v[ROM_LAT-1];
  assign ret_ch = tag_ch[ROM_LAT-1];

  // Return path: only the owning channel's result register is written.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= ret_v & ~ret_ch;
      rvalid1 <= ret_v &  ret_ch;
      if (ret_v && !ret_ch) begin
        rdata0 <= rom_dout;
      end
      if (ret_v && ret_ch) begin
        rdata1 <= rom_dout;
      end
    end
  end

endmodule

// File: tb/tb_coef_rom_arbiter.sv
// Directed bench for coef_rom_arbiter. Three instances run at ROM_LAT 1, 3
// and 2 from one shared stimulus. Each instance has its own ROM model. The
// expected grants and addresses in every vector are written by hand. The
// bench turns them into expected returns at grant cycle + ROM_LAT + 1.
module tb_coef_rom_arbiter;

  localparam int unsigned AW   = 11;
  localparam int unsigned DW   = 48;
  localparam int unsigned NCYC = 128;

  logic Fg_CLK = 1'b0;
  logic RESETn = 1'b0;
  logic en = 1'b0;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;

  logic [2:0] gnt0_v, gnt1_v, rvalid0_v, rvalid1_v, rom_ce_v, busy_v;
  logic [AW-1:0] rom_ad_v [3];
  logic [DW-1:0] rdata0_v [3];
  logic [DW-1:0] rdata1_v [3];
  logic [DW-1:0] rom_dout_v [3];

  int n_vec = 0;
  int n_miss = 0;
  int t = 0;

  logic          exp_rv   [3][2][NCYC];
  logic [AW-1:0] exp_a    [3][2][NCYC];
  logic          exp_busy [3][NCYC];
  logic [DW-1:0] exp_rd   [3][2];
  logic [AW-1:0] exp_last;

  always #5 Fg_CLK = ~Fg_CLK;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {13'h1C3, a, 13'h0B7, ~a};
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 2;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int unsigned LAT = (gi == 0) ? 1 : (gi == 1) ? 3 : 2;
    logic [DW-1:0] pipe [LAT];

    always @(posedge Fg_CLK) begin
      pipe[0] <= rom_word(rom_ad_v[gi]);
      for (int k = 1; k < int'(LAT); k++) pipe[k] <= pipe[k-1];
    end
    assign rom_dout_v[gi] = pipe[LAT-1];

    coef_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) u_dut (
      .Fg_CLK   (Fg_CLK),
      .RESETn   (RESETn),
      .en       (en),
      .req0     (req0),
      .addr0    (addr0),
      .gnt0     (gnt0_v[gi]),
      .rvalid0  (rvalid0_v[gi]),
      .rdata0   (rdata0_v[gi]),
      .req1     (req1),
      .addr1    (addr1),
      .gnt1     (gnt1_v[gi]),
      .rvalid1  (rvalid1_v[gi]),
      .rdata1   (rdata1_v[gi]),
      .rom_ad   (rom_ad_v[gi]),
      .rom_ce   (rom_ce_v[gi]),
      .rom_dout (rom_dout_v[gi]),
      .busy     (busy_v[gi])
    );
  end

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", tag, t, got, exp);
    end
  endtask

  task automatic clear_future();
    for (int i = 0; i < 3; i++) begin
      for (int tt = t; tt < int'(NCYC); tt++) begin
        exp_rv[i][0][tt] = 1'b0;
        exp_rv[i][1][tt] = 1'b0;
        exp_busy[i][tt]  = 1'b0;
      end
    end
  endtask

  // One cycle: apply inputs, check every output against expectations, then
  // schedule the returns for the expected grant (x0/x1).
  task automatic cyc(input logic e, input logic r0, input logic [AW-1:0] a0,
                     input logic r1, input logic [AW-1:0] a1,
                     input logic x0, input logic x1);
    logic [AW-1:0] xad;
    int lat;
    int c;
    en = e; req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    #2;
    xad = x0 ? a0 : (x1 ? a1 : exp_last);
    c = x1 ? 1 : 0;
    chk_val("gnt0", {61'd0, gnt0_v}, {61'd0, {3{x0}}});
    chk_val("gnt1", {61'd0, gnt1_v}, {61'd0, {3{x1}}});
    for (int i = 0; i < 3; i++) begin
      lat = lat_of(i);
      for (int ch = 0; ch < 2; ch++)
        if (exp_rv[i][ch][t]) exp_rd[i][ch] = rom_word(exp_a[i][ch][t]);
      chk_val($sformatf("rom_ad[L%0d]", lat), {53'd0, rom_ad_v[i]}, {53'd0, xad});
      chk_val($sformatf("rom_ce[L%0d]", lat), {63'd0, rom_ce_v[i]}, {63'd0, x0 | x1 | exp_busy[i][t]});
      chk_val($sformatf("busy[L%0d]", lat), {63'd0, busy_v[i]}, {63'd0, exp_busy[i][t]});
      chk_val($sformatf("rvalid0[L%0d]", lat), {63'd0, rvalid0_v[i]}, {63'd0, exp_rv[i][0][t]});
      chk_val($sformatf("rvalid1[L%0d]", lat), {63'd0, rvalid1_v[i]}, {63'd0, exp_rv[i][1][t]});
      chk_val($sformatf("rdata0[L%0d]", lat), {16'd0, rdata0_v[i]}, {16'd0, exp_rd[i][0]});
      chk_val($sformatf("rdata1[L%0d]", lat), {16'd0, rdata1_v[i]}, {16'd0, exp_rd[i][1]});
      if (x0 || x1) begin
        exp_rv[i][c][t+lat+1] = 1'b1;
        exp_a[i][c][t+lat+1]  = xad;
        for (int k = 1; k <= lat; k++) exp_busy[i][t+k] = 1'b1;
      end
    end
    exp_last = xad;
    @(posedge Fg_CLK); #1;
    t++;
  endtask

  initial begin
    exp_last = '0;
    for (int i = 0; i < 3; i++) begin
      exp_rd[i][0] = '0;
      exp_rd[i][1] = '0;
    end
    clear_future();

    // Reset state, with ch0 already requesting address 0.
    en = 1'b1; req0 = 1'b1; addr0 = 11'h000;
    repeat (2) @(posedge Fg_CLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_val("rst_rvalid", {62'd0, rvalid1_v[i], rvalid0_v[i]}, 64'd0);
      chk_val("rst_rdata0", {16'd0, rdata0_v[i]}, 64'd0);
      chk_val("rst_rdata1", {16'd0, rdata1_v[i]}, 64'd0);
      chk_val("rst_busy", {63'd0, busy_v[i]}, 64'd0);
    end
    RESETn = 1'b1;

    // 1: first cycle after release grants ch0; return appears later.
    cyc(1, 1, 11'h000, 0, 11'h000, 1, 0);
    repeat (4) cyc(1, 0, 11'h000, 0, 11'h000, 0, 0);

    // 3: ch1 streaming 0x100..0x107, back-to-back grants and returns.
    for (int k = 0; k < 8; k++) cyc(1, 0, 11'h000, 1, 11'(11'h100 + k), 0, 1);
    repeat (5) cyc(1, 0, 11'h000, 0, 11'h107, 0, 0);

    // 2: continuous contention alternates starting with ch0.
    for (int k = 0; k < 8; k++) cyc(1, 1, 11'h010, 1, 11'h7FF, (k % 2) == 0, (k % 2) == 1);
    repeat (5) cyc(1, 0, 11'h010, 0, 11'h7FF, 0, 0);

    // 4: enable low blocks the grant; first enabled cycle grants ch0.
    repeat (5) cyc(0, 1, 11'h2A5, 0, 11'h000, 0, 0);
    cyc(1, 1, 11'h2A5, 0, 11'h000, 1, 0);

    // 6: idle after 0x2A5: address held, ce drops, results held.
    repeat (6) cyc(1, 0, 11'h000, 0, 11'h000, 0, 0);

    // Withdrawn request: no grant while disabled, then nothing follows.
    cyc(0, 0, 11'h333, 1, 11'h444, 0, 0);
    cyc(1, 0, 11'h333, 0, 11'h444, 0, 0);

    // 5: grant ch1, then pulse reset during the next cycle.
    cyc(1, 0, 11'h000, 1, 11'h055, 0, 1);
    req0 = 1'b0; req1 = 1'b0;
    #1;
    RESETn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_val("rstmid_rdata1", {16'd0, rdata1_v[i]}, 64'd0);
      chk_val("rstmid_rdata0", {16'd0, rdata0_v[i]}, 64'd0);
      chk_val("rstmid_busy", {63'd0, busy_v[i]}, 64'd0);
      chk_val("rstmid_rvalid1", {63'd0, rvalid1_v[i]}, 64'd0);
      exp_rd[i][0] = '0;
      exp_rd[i][1] = '0;
    end
    clear_future();
    exp_last = '0;
    @(posedge Fg_CLK); #2;
    RESETn = 1'b1;
    #1;
    t++;
    for (int i = 0; i < 3; i++)
      chk_val("rstrel_rvalid1", {63'd0, rvalid1_v[i]}, 64'd0);
    @(posedge Fg_CLK); #1;
    t++;

    // After reset ch0 wins the tie; the dropped ch1 read never returns.
    cyc(1, 1, 11'h123, 1, 11'h456, 1, 0);
    cyc(1, 0, 11'h123, 1, 11'h456, 0, 1);
    repeat (5) cyc(1, 0, 11'h000, 0, 11'h000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
